// File: rtl/fifo_rr_arbiter.sv
// Round-robin mover from four source VC FIFOs to four destination FIFOs.
// Pops are issued one per cycle and the word reaches its destination two cycles later.
module fifo_rr_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [3:0]              src_empty,
  input  logic [4*DATA_WIDTH-1:0] src_data,
  output logic [3:0]              src_rd,
  input  logic [3:0]              dst_afull,
  input  logic [3:0]              dst_full,
  output logic [3:0]              dst_wr,
  output logic [DATA_WIDTH-1:0]   dst_data,
  output logic [1:0]              grant_id,
  output logic                    busy,
  output logic                    error,
  output logic [COUNT_WIDTH-1:0]  xfer_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state;
  logic                  v1;
  logic [1:0]            s1;
  logic                  found;
  logic                  grant;
  logic [1:0]            pick;
  logic [1:0]            cand;
  logic [DATA_WIDTH-1:0] s1_word;
  logic [1:0]            dest;

  // Search starts just after the last granted source, so k=4 wraps back to it.
  always_comb begin
    found = 1'b0;
    pick  = grant_id;
    cand  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = grant_id + 2'(k);
      if (!found && !src_empty[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    grant = (state == ACTIVE) && en && (dst_afull == '0) && found;
  end

  always_comb begin
    s1_word = src_data[32'(s1)*DATA_WIDTH +: DATA_WIDTH];
    dest    = s1_word[DATA_WIDTH-1 -: 2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src_rd     <= '0;
      grant_id   <= 2'd3;
      v1         <= 1'b0;
      s1         <= '0;
      dst_wr     <= '0;
      dst_data   <= '0;
      xfer_count <= '0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (en)  state <= ACTIVE;
        ACTIVE:  if (!en) state <= IDLE;
        default: state <= IDLE;
      endcase

      src_rd <= grant ? (4'b0001 << pick) : '0;
      if (grant) grant_id <= pick;

      // grant_id already names the source popped this cycle.
      v1 <= |src_rd;
      s1 <= grant_id;

      if (v1) begin
        dst_data   <= s1_word;
        dst_wr     <= 4'b0001 << dest;
        xfer_count <= xfer_count + COUNT_WIDTH'(1);
      end else begin
        dst_wr <= '0;
      end

      if (|(dst_wr & dst_full)) error <= 1'b1;

      busy <= en | grant | (|src_rd) | v1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with simple source FIFO models.
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  src_empty;
  logic [31:0] src_data;
  logic [3:0]  src_rd;
  logic [3:0]  dst_afull;
  logic [3:0]  dst_full;
  logic [3:0]  dst_wr;
  logic [7:0]  dst_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        error;
  logic [15:0] xfer_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [4][16];
  logic [4:0] wptr [4];
  logic [4:0] rptr [4];
  logic [7:0] dout [4];

  fifo_rr_arbiter #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .en(en), .src_empty(src_empty), .src_data(src_data),
    .src_rd(src_rd), .dst_afull(dst_afull), .dst_full(dst_full), .dst_wr(dst_wr),
    .dst_data(dst_data), .grant_id(grant_id), .busy(busy), .error(error),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // Source FIFO model: registered data_out; empty accounts for a pop in progress.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        rptr[i] <= '0;
        dout[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (src_rd[i] && wptr[i] != rptr[i]) begin
          dout[i] <= mem[i][rptr[i][3:0]];
          rptr[i] <= rptr[i] + 5'd1;
        end
      end
    end
  end

  always_comb begin
    src_empty = '1;
    src_data  = '0;
    for (int i = 0; i < 4; i++) begin
      src_empty[i] = ((wptr[i] - rptr[i]) == 5'd0) ||
                     (((wptr[i] - rptr[i]) == 5'd1) && src_rd[i]);
      src_data[i*8 +: 8] = dout[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int src, input logic [7:0] w);
    mem[src][wptr[src][3:0]] = w;
    wptr[src] = wptr[src] + 5'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    dst_afull = '0;
    dst_full = '0;
    for (int i = 0; i < 4; i++) wptr[i] = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (src_rd !== 4'b0000) begin errors++; $display("FAIL reset_src_rd got %b exp 0000", src_rd); end
    checks++; if (dst_wr !== 4'b0000) begin errors++; $display("FAIL reset_dst_wr got %b exp 0000", dst_wr); end
    checks++; if (dst_data !== 8'h00) begin errors++; $display("FAIL reset_dst_data got %h exp 00", dst_data); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL reset_grant_id got %0d exp 3", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error); end
    checks++; if (xfer_count !== 16'd0) begin errors++; $display("FAIL reset_xfer_count got %0d exp 0", xfer_count); end
  endtask

  task automatic test_single_source();
    do_reset();
    push(0, 8'h41);
    push(0, 8'h82);
    en = 1'b1;
    step(); step();
    checks++; if (src_rd !== 4'b0001) begin errors++; $display("FAIL single_rd0 got %b exp 0001", src_rd); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_gid got %0d exp 0", grant_id); end
    step();
    checks++; if (src_rd !== 4'b0001) begin errors++; $display("FAIL single_rd1 got %b exp 0001", src_rd); end
    step();
    checks++; if (src_rd !== 4'b0000) begin errors++; $display("FAIL single_rd2 got %b exp 0000", src_rd); end
    checks++; if (dst_wr !== 4'b0010) begin errors++; $display("FAIL single_wr0 got %b exp 0010", dst_wr); end
    checks++; if (dst_data !== 8'h41) begin errors++; $display("FAIL single_data0 got %h exp 41", dst_data); end
    step();
    checks++; if (dst_wr !== 4'b0100) begin errors++; $display("FAIL single_wr1 got %b exp 0100", dst_wr); end
    checks++; if (dst_data !== 8'h82) begin errors++; $display("FAIL single_data1 got %h exp 82", dst_data); end
    step();
    checks++; if (dst_wr !== 4'b0000) begin errors++; $display("FAIL single_wr2 got %b exp 0000", dst_wr); end
    checks++; if (xfer_count !== 16'd2) begin errors++; $display("FAIL single_count got %0d exp 2", xfer_count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rd;
    logic [7:0] exp_w;
    do_reset();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++) push(i, 8'(i * 64 + j));
    en = 1'b1;
    step(); step();
    for (int k = 0; k < 14; k++) begin
      exp_rd = (k < 12) ? (4'b0001 << (k % 4)) : 4'b0000;
      checks++; if (src_rd !== exp_rd) begin errors++; $display("FAIL rr_rd k=%0d got %b exp %b", k, src_rd, exp_rd); end
      if (k < 12) begin
        checks++; if (grant_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_gid k=%0d got %0d exp %0d", k, grant_id, k % 4); end
      end
      if (k >= 2) begin
        exp_w = 8'(((k - 2) % 4) * 64 + (k - 2) / 4);
        checks++; if (dst_wr !== (4'b0001 << ((k - 2) % 4))) begin errors++; $display("FAIL rr_wr k=%0d got %b", k, dst_wr); end
        checks++; if (dst_data !== exp_w) begin errors++; $display("FAIL rr_data k=%0d got %h exp %h", k, dst_data, exp_w); end
      end
      step();
    end
    checks++; if (xfer_count !== 16'd12) begin errors++; $display("FAIL rr_count got %0d exp 12", xfer_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++) push(i, 8'(i * 64 + j));
    en = 1'b1;
    step(); step();
    checks++; if (src_rd !== 4'b0001) begin errors++; $display("FAIL bp_rd_pre0 got %b exp 0001", src_rd); end
    step();
    checks++; if (src_rd !== 4'b0010) begin errors++; $display("FAIL bp_rd_pre1 got %b exp 0010", src_rd); end
    dst_afull = 4'b0100;
    for (int j = 1; j <= 5; j++) begin
      step();
      checks++; if (src_rd !== 4'b0000) begin errors++; $display("FAIL bp_rd_blocked j=%0d got %b exp 0000", j, src_rd); end
      if (j == 5) dst_afull = 4'b0000;
    end
    step();
    checks++; if (src_rd !== 4'b0100) begin errors++; $display("FAIL bp_rd_resume got %b exp 0100", src_rd); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL bp_gid_resume got %0d exp 2", grant_id); end
  endtask

  task automatic test_overflow();
    do_reset();
    push(0, 8'h45);
    en = 1'b1;
    step(); step(); step(); step();
    checks++; if (dst_wr !== 4'b0010) begin errors++; $display("FAIL ovf_wr got %b exp 0010", dst_wr); end
    checks++; if (dst_data !== 8'h45) begin errors++; $display("FAIL ovf_data got %h exp 45", dst_data); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf_error_early got %b exp 0", error); end
    dst_full = 4'b0010;
    step();
    dst_full = 4'b0000;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error_set got %b exp 1", error); end
    for (int j = 0; j < 3; j++) begin
      step();
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error_sticky j=%0d got %b exp 1", j, error); end
    end
  endtask

  task automatic test_drop_en();
    do_reset();
    push(0, 8'hC3);
    push(0, 8'h10);
    en = 1'b1;
    step(); step();
    checks++; if (src_rd !== 4'b0001) begin errors++; $display("FAIL drop_rd got %b exp 0001", src_rd); end
    en = 1'b0;
    step();
    checks++; if (src_rd !== 4'b0000) begin errors++; $display("FAIL drop_no_rd got %b exp 0000", src_rd); end
    step();
    checks++; if (dst_wr !== 4'b1000) begin errors++; $display("FAIL drop_wr got %b exp 1000", dst_wr); end
    checks++; if (dst_data !== 8'hC3) begin errors++; $display("FAIL drop_data got %h exp c3", dst_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_wr got %b exp 1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy_after1 got %b exp 0", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy_after2 got %b exp 0", busy); end
    checks++; if (src_rd !== 4'b0000) begin errors++; $display("FAIL drop_rd_late got %b exp 0000", src_rd); end
    checks++; if (xfer_count !== 16'd1) begin errors++; $display("FAIL drop_count got %0d exp 1", xfer_count); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    push(0, 8'h82);
    push(1, 8'h43);
    en = 1'b1;
    step(); step();
    checks++; if (src_rd !== 4'b0001) begin errors++; $display("FAIL mid_rd got %b exp 0001", src_rd); end
    step();
    reset = 1'b1;
    #1;
    checks++; if (src_rd !== 4'b0000) begin errors++; $display("FAIL mid_src_rd got %b exp 0000", src_rd); end
    checks++; if (dst_wr !== 4'b0000) begin errors++; $display("FAIL mid_dst_wr got %b exp 0000", dst_wr); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL mid_grant_id got %0d exp 3", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    checks++; if (xfer_count !== 16'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", xfer_count); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL mid_error got %b exp 0", error); end
    en = 1'b0;
    for (int i = 0; i < 4; i++) wptr[i] = '0;
    step();
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++; if (dst_wr !== 4'b0000) begin errors++; $display("FAIL mid_no_wr j=%0d got %b exp 0000", j, dst_wr); end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en = 1'b0;
    dst_afull = '0;
    dst_full = '0;
    for (int i = 0; i < 4; i++) wptr[i] = '0;
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_drop_en();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
